rom_access_ctrl: RTL and testbench
==================================

ROM_ACCESS_CTRL -- requirements
Module: rom_access_ctrl

Interface
REQ-001 Parameter MEM_ADDR_WIDTH, default 13, word-address width of the attached 32-bit dual-port block ROM.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ld_valid  input  1  loader presents a write word.
REQ-005 ld_addr  input  MEM_ADDR_WIDTH  loader word address.
REQ-006 ld_data  input  32  loader write data.
REQ-007 ld_ready  output  1  write accepted when ld_valid & ld_ready.
REQ-008 ld_done  input  1  pulse: image load complete.
REQ-009 reload_req  input  1  pulse: return to load mode.
REQ-010 r0_req / r1_req  input  1 each  read request, held until granted.
REQ-011 r0_addr / r1_addr  input  MEM_ADDR_WIDTH each  read word address.
REQ-012 r0_gnt / r1_gnt  output  1 each  request granted this cycle.
REQ-013 r0_rvalid / r1_rvalid  output  1 each  read data valid.
REQ-014 r0_rdata / r1_rdata  output  32 each  read data.
REQ-015 mem_addr_in  output  MEM_ADDR_WIDTH  ROM write address.
REQ-016 mem_data_in  output  32  ROM write data.
REQ-017 mem_size_decode  output  4  4'b1111 = write enable, 4'b0000 = idle.
REQ-018 mem_addr_out  output  MEM_ADDR_WIDTH  ROM read address.
REQ-019 mem_data_out  input  32  ROM read data, valid one cycle after address.
REQ-020 run_mode  output  1  high in RUN state.
REQ-021 load_count  output  MEM_ADDR_WIDTH+1  words written since last LOAD entry.
REQ-022 load_sum  output  32  modulo-2^32 sum of words written since last LOAD entry.

Function
REQ-023 FSM states LOAD, RUN, FLUSH; LOAD->RUN on ld_done; RUN->FLUSH on reload_req; FLUSH->LOAD when no read in flight (one cycle if none, two if one pending).
REQ-024 ld_ready is 1 in LOAD, 0 in RUN/FLUSH; writes never stall in LOAD.
REQ-025 Accepted write registered; issued next cycle: mem_addr_in/mem_data_in = captured values, mem_size_decode = 4'b1111, else 4'b0000.
REQ-026 load_count increments and load_sum adds ld_data on each acceptance; both wrap; cleared on entering LOAD.
REQ-027 ld_valid and ld_done in same cycle: write accepted, then state goes RUN.
REQ-028 Grants only in RUN and not while a write is pending in the write register (read-after-write guard).
REQ-029 Grant combinational: mem_addr_out = granted requester's address; at most one gnt per cycle.
REQ-030 Round-robin: single requester granted immediately; both requesting -> requester not granted last; pointer favours r0 after reset.
REQ-031 Read tag registered at grant; next cycle exactly one rN_rvalid = 1 with rN_rdata = mem_data_out; other rvalid 0.
REQ-032 reload_req in same cycle as a grant: grant honoured, data still returned, then FLUSH waits for it.
REQ-033 reload_req outside RUN and ld_done outside LOAD are ignored.
REQ-034 Back-to-back reads: one grant per cycle, full throughput.

Reset
REQ-035 rst asserted: state LOAD, ld_ready 1 after release, all gnt/rvalid 0, mem_size_decode 4'b0000, load_count 0, load_sum 0, rr pointer to r0, pending write and read tag discarded; run_mode 0.
REQ-036 Reset mid-write or mid-read drops the operation; no ROM write issued after rst asserts.

Structure
REQ-037 State encodings and MEM_SIZE_WRITE/MEM_SIZE_IDLE constants in shared GlobalDefine include.
REQ-038 One sub-module natural: rr_arbiter2 (2-way round-robin, req/gnt/last pointer).

Verification
REQ-039 Load 4 words 0x11,0x22,0x33,0x44 at addr 0..3, ld_done -> load_count 4, load_sum 0xAA, four ROM writes each one cycle after acceptance, run_mode 1.
REQ-040 RUN, r0_req addr 2 alone -> r0_gnt same cycle, r0_rvalid next cycle rdata 0x33.
REQ-041 r0 and r1 both held 4 cycles -> grants r0,r1,r0,r1; rvalid routed to matching port one cycle later.
REQ-042 Last write with ld_done same cycle, r1_req held -> no gnt until write issued, then r1_gnt.
REQ-043 reload_req with grant same cycle -> data returned, FLUSH, LOAD, count/sum 0, ld_ready 1.
REQ-044 rst pulse mid-read and mid-write -> no rvalid, no mem_size_decode 4'b1111, outputs at reset values.

Source files
------------

// File: rtl/rom_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rom_access_ctrl_pkg
// Shared definitions for the ROM access controller:
//   - controller state encodings (LOAD / RUN / FLUSH)
//   - ROM byte-lane write strobe codes driven on mem_size_decode
//   - read tag layout carried from grant to data return
// ---------------------------------------------------------------------------
package rom_access_ctrl_pkg;

    // Controller states
    localparam logic [1:0] STATE_LOAD  = 2'd0;
    localparam logic [1:0] STATE_RUN   = 2'd1;
    localparam logic [1:0] STATE_FLUSH = 2'd2;

    // ROM write strobe: all four byte lanes on a write, none when idle
    localparam logic [3:0] MEM_SIZE_WRITE = 4'b1111;
    localparam logic [3:0] MEM_SIZE_IDLE  = 4'b0000;

    // A read in flight: valid, and which requester (0 = r0, 1 = r1) owns it
    typedef struct packed {
        logic valid;
        logic port;
    } readTag_t;

    function automatic logic [3:0] memSizeFor(input logic writeEn);
        return writeEn ? MEM_SIZE_WRITE : MEM_SIZE_IDLE;
    endfunction

endpackage

// File: rtl/rom_access_ctrl_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter with a combinational grant.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   enable  : arbitration allowed this cycle (otherwise no grant)
//   req     : request vector, bit 0 = r0, bit 1 = r1
//   gnt     : one-hot (or zero) grant vector, same-cycle
// A lone requester wins immediately. With both requesting, the one that
// was not granted last wins. The last-grant pointer resets to r1 so that
// r0 is favoured on the first contended cycle after reset.
// ---------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic lastGnt;   // 1 = r1 was granted most recently

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = lastGnt ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGnt <= 1'b1;
        end else if (|gnt) begin
            lastGnt <= gnt[1];
        end
    end

endmodule

// File: rtl/rom_access_ctrl.sv
// ---------------------------------------------------------------------------
// rom_access_ctrl
// Front-end for a 32-bit dual-port block ROM. In LOAD the ROM image is
// written through the loader port; in RUN two read requesters share the
// read port through a round-robin arbiter; FLUSH drains an outstanding
// read before returning to LOAD.
//
// Ports
//   clk, rst                  : clock, asynchronous active-high reset
//   ld_valid/ld_addr/ld_data  : loader write word
//   ld_ready                  : loader write accepted (high in LOAD)
//   ld_done                   : pulse, image complete (LOAD -> RUN)
//   reload_req                : pulse, go back to LOAD (RUN -> FLUSH)
//   rN_req/rN_addr            : read request, held until rN_gnt
//   rN_gnt                    : request granted this cycle
//   rN_rvalid/rN_rdata        : read data, one cycle after grant
//   mem_addr_in/mem_data_in   : ROM write address/data
//   mem_size_decode           : ROM write strobe (1111 write, 0000 idle)
//   mem_addr_out              : ROM read address
//   mem_data_out              : ROM read data, one cycle after address
//   run_mode                  : high in RUN
//   load_count/load_sum       : words written / their sum since LOAD entry
//
// States
//   LOAD  | loader writes accepted, no reads
//   RUN   | reads arbitrated, loader stalled
//   FLUSH | waiting for the last granted read to return
// ---------------------------------------------------------------------------
module rom_access_ctrl
    import rom_access_ctrl_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 13
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      ld_valid,
    input  logic [MEM_ADDR_WIDTH-1:0] ld_addr,
    input  logic [31:0]               ld_data,
    output logic                      ld_ready,
    input  logic                      ld_done,
    input  logic                      reload_req,

    input  logic                      r0_req,
    input  logic [MEM_ADDR_WIDTH-1:0] r0_addr,
    output logic                      r0_gnt,
    output logic                      r0_rvalid,
    output logic [31:0]               r0_rdata,

    input  logic                      r1_req,
    input  logic [MEM_ADDR_WIDTH-1:0] r1_addr,
    output logic                      r1_gnt,
    output logic                      r1_rvalid,
    output logic [31:0]               r1_rdata,

    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_in,
    output logic [31:0]               mem_data_in,
    output logic [3:0]                mem_size_decode,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_out,
    input  logic [31:0]               mem_data_out,

    output logic                      run_mode,
    output logic [MEM_ADDR_WIDTH:0]   load_count,
    output logic [31:0]               load_sum
);

    logic [1:0]                state;
    logic [1:0]                stateNext;
    logic                      enterLoad;

    logic                      wrAccept;
    logic                      wrPending;
    logic [MEM_ADDR_WIDTH-1:0] wrAddr;
    logic [31:0]               wrData;

    logic                      grantEn;
    logic [1:0]                reqVec;
    logic [1:0]                gntVec;
    readTag_t                  rdTag;

    logic [MEM_ADDR_WIDTH:0]   loadCount;
    logic [31:0]               loadSum;

    // -----------------------------------------------------------------------
    // State machine
    // -----------------------------------------------------------------------
    always_comb begin
        stateNext = state;
        case (state)
            STATE_LOAD:  if (ld_done)       stateNext = STATE_RUN;
            STATE_RUN:   if (reload_req)    stateNext = STATE_FLUSH;
            STATE_FLUSH: if (!rdTag.valid)  stateNext = STATE_LOAD;
            default:                        stateNext = STATE_LOAD;
        endcase
    end

    assign enterLoad = (state != STATE_LOAD) && (stateNext == STATE_LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STATE_LOAD;
        end else begin
            state <= stateNext;
        end
    end

    assign ld_ready = (state == STATE_LOAD);
    assign run_mode = (state == STATE_RUN);

    // -----------------------------------------------------------------------
    // Write path: an accepted word is registered and driven to the ROM on
    // the following cycle. Loader never stalls while in LOAD.
    // -----------------------------------------------------------------------
    assign wrAccept = ld_valid & ld_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPending <= 1'b0;
            wrAddr    <= '0;
            wrData    <= '0;
        end else begin
            wrPending <= wrAccept;
            if (wrAccept) begin
                wrAddr <= ld_addr;
                wrData <= ld_data;
            end
        end
    end

    assign mem_addr_in     = wrAddr;
    assign mem_data_in     = wrData;
    assign mem_size_decode = memSizeFor(wrPending);

    // Image statistics, restarted every time LOAD is (re)entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loadCount <= '0;
            loadSum   <= '0;
        end else if (enterLoad) begin
            loadCount <= '0;
            loadSum   <= '0;
        end else if (wrAccept) begin
            loadCount <= loadCount + {{MEM_ADDR_WIDTH{1'b0}}, 1'b1};
            loadSum   <= loadSum + ld_data;
        end
    end

    assign load_count = loadCount;
    assign load_sum   = loadSum;

    // -----------------------------------------------------------------------
    // Read path. Reads are held off while the last loader word is still in
    // the write register so a read can never see stale ROM contents.
    // -----------------------------------------------------------------------
    assign grantEn = run_mode & ~wrPending;
    assign reqVec  = {r1_req, r0_req};

    rr_arbiter2 u_arbiter (
        .clk    (clk),
        .rst    (rst),
        .enable (grantEn),
        .req    (reqVec),
        .gnt    (gntVec)
    );

    assign r0_gnt       = gntVec[0];
    assign r1_gnt       = gntVec[1];
    assign mem_addr_out = gntVec[1] ? r1_addr : r0_addr;

    // Tag follows the ROM's one-cycle read latency to steer the data back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdTag <= '0;
        end else begin
            rdTag.valid <= |gntVec;
            rdTag.port  <= gntVec[1];
        end
    end

    assign r0_rvalid = rdTag.valid & ~rdTag.port;
    assign r1_rvalid = rdTag.valid &  rdTag.port;
    assign r0_rdata  = r0_rvalid ? mem_data_out : 32'h0;
    assign r1_rdata  = r1_rvalid ? mem_data_out : 32'h0;

endmodule

// File: tb/tb_rom_access_ctrl.sv
module tb_rom_access_ctrl;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid, ld_ready, ld_done, reload_req;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          r0_req, r1_req, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [31:0]   r0_rdata, r1_rdata;
    logic [AW-1:0] mem_addr_in, mem_addr_out;
    logic [31:0]   mem_data_in, mem_data_out;
    logic [3:0]    mem_size_decode;
    logic          run_mode;
    logic [AW:0]   load_count;
    logic [31:0]   load_sum;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct { int port; logic [31:0] data; int cycle; } rdExp_t;
    typedef struct { logic [AW-1:0] addr; logic [31:0] data; int cycle; } wrExp_t;
    rdExp_t rdQ[$];
    wrExp_t wrQ[$];

    logic [31:0] rom    [0:63];
    logic [31:0] romExp [0:63];
    logic        expLast;     // 1 = r1 granted last
    int          expCount;
    logic [31:0] expSum;

    rom_access_ctrl #(.MEM_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
        .ld_done(ld_done), .reload_req(reload_req),
        .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_addr_in(mem_addr_in), .mem_data_in(mem_data_in), .mem_size_decode(mem_size_decode),
        .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
        .run_mode(run_mode), .load_count(load_count), .load_sum(load_sum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Dual-port ROM model: write on strobe, registered read
    always @(posedge clk) begin
        if (mem_size_decode == 4'b1111) rom[mem_addr_in[5:0]] <= mem_data_in;
        mem_data_out <= rom[mem_addr_out[5:0]];
    end

    // Read data scoreboard
    rdExp_t rdE;
    always @(negedge clk) begin
        if (r0_rvalid || r1_rvalid) begin
            checks++;
            if (r0_rvalid && r1_rvalid) begin
                failures++;
                $display("FAIL rvalid_both r0_rvalid=%0b r1_rvalid=%0b required one", r0_rvalid, r1_rvalid);
            end else if (rdQ.size() == 0) begin
                failures++;
                $display("FAIL rvalid_unexpected r0_rvalid=%0b r1_rvalid=%0b required none at cycle %0d", r0_rvalid, r1_rvalid, cyc);
            end else begin
                rdE = rdQ.pop_front();
                if ((r1_rvalid ? 1 : 0) !== rdE.port || (r1_rvalid ? r1_rdata : r0_rdata) !== rdE.data || cyc !== rdE.cycle) begin
                    failures++;
                    $display("FAIL read_return port=%0d data=%h cycle=%0d required port=%0d data=%h cycle=%0d",
                             r1_rvalid ? 1 : 0, r1_rvalid ? r1_rdata : r0_rdata, cyc, rdE.port, rdE.data, rdE.cycle);
                end
            end
        end
    end

    // ROM write scoreboard
    wrExp_t wrE;
    always @(negedge clk) begin
        if (mem_size_decode !== 4'b0000) begin
            checks++;
            if (mem_size_decode !== 4'b1111) begin
                failures++;
                $display("FAIL mem_size_decode actual=%b required 1111 or 0000", mem_size_decode);
            end else if (wrQ.size() == 0) begin
                failures++;
                $display("FAIL rom_write_unexpected addr=%h data=%h required none", mem_addr_in, mem_data_in);
            end else begin
                wrE = wrQ.pop_front();
                if (mem_addr_in !== wrE.addr || mem_data_in !== wrE.data || cyc !== wrE.cycle) begin
                    failures++;
                    $display("FAIL rom_write addr=%h data=%h cycle=%0d required addr=%h data=%h cycle=%0d",
                             mem_addr_in, mem_data_in, cyc, wrE.addr, wrE.data, wrE.cycle);
                end
            end
        end
    end

    task automatic idleInputs();
        ld_valid = 0; ld_addr = '0; ld_data = '0; ld_done = 0; reload_req = 0;
        r0_req = 0; r0_addr = '0; r1_req = 0; r1_addr = '0;
    endtask

    task automatic test_reset();
        rst = 1;
        idleInputs();
        r0_req = 1; r1_req = 1; ld_valid = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL reset_ld_ready actual=%0b required=1", ld_ready); end
        checks++; if (run_mode !== 1'b0) begin failures++; $display("FAIL reset_run_mode actual=%0b required=0", run_mode); end
        checks++; if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid} !== 4'b0000) begin failures++;
            $display("FAIL reset_gnt_rvalid actual=%b required=0000", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid}); end
        checks++; if (mem_size_decode !== 4'b0000) begin failures++; $display("FAIL reset_decode actual=%b required=0000", mem_size_decode); end
        checks++; if (load_count !== '0 || load_sum !== 32'h0) begin failures++;
            $display("FAIL reset_count_sum actual=%0d/%h required=0/0", load_count, load_sum); end
        @(negedge clk);
        idleInputs();
        rst = 0;
        expLast = 1'b1;
        #1;
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ld_ready actual=%0b required=1", ld_ready); end
    endtask

    task automatic test_load();
        expCount = 0; expSum = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ld_valid = 1; ld_addr = AW'(i); ld_data = 32'(i + 1) * 32'h11;
            #1;
            checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL load_ready word=%0d actual=%0b required=1", i, ld_ready); end
            wrQ.push_back('{ld_addr, ld_data, cyc + 1});
            romExp[i] = ld_data;
            expCount++; expSum += ld_data;
        end
        @(negedge clk);
        ld_valid = 0; ld_done = 1;
        #1;
        checks++; if (load_count !== (AW+1)'(expCount) || load_sum !== expSum) begin failures++;
            $display("FAIL load_stats actual=%0d/%h required=%0d/%h", load_count, load_sum, expCount, expSum); end
        @(negedge clk);
        ld_done = 0;
        #1;
        checks++; if (run_mode !== 1'b1 || ld_ready !== 1'b0) begin failures++;
            $display("FAIL load_to_run run_mode=%0b ld_ready=%0b required 1/0", run_mode, ld_ready); end
    endtask

    task automatic test_single_read();
        @(negedge clk);
        r0_req = 1; r0_addr = 2;
        #1;
        checks++; if ({r1_gnt, r0_gnt} !== 2'b01 || mem_addr_out !== AW'(2)) begin failures++;
            $display("FAIL single_r0 gnt=%b addr=%0d required 01/2", {r1_gnt, r0_gnt}, mem_addr_out); end
        rdQ.push_back('{0, romExp[2], cyc + 1}); expLast = 0;
        @(negedge clk);
        r0_req = 0; r1_req = 1; r1_addr = 1;
        #1;
        checks++; if ({r1_gnt, r0_gnt} !== 2'b10 || mem_addr_out !== AW'(1)) begin failures++;
            $display("FAIL single_r1 gnt=%b addr=%0d required 10/1", {r1_gnt, r0_gnt}, mem_addr_out); end
        rdQ.push_back('{1, romExp[1], cyc + 1}); expLast = 1;
        @(negedge clk);
        r1_req = 0;
        #1;
        checks++; if ({r1_gnt, r0_gnt} !== 2'b00) begin failures++; $display("FAIL single_idle gnt=%b required 00", {r1_gnt, r0_gnt}); end
    endtask

    task automatic test_round_robin();
        logic [1:0] expG;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            r0_req = 1; r0_addr = 0; r1_req = 1; r1_addr = 3;
            #1;
            expG = expLast ? 2'b01 : 2'b10;
            checks++; if ({r1_gnt, r0_gnt} !== expG || mem_addr_out !== (expG[1] ? AW'(3) : AW'(0))) begin failures++;
                $display("FAIL round_robin step=%0d gnt=%b addr=%0d required %b", i, {r1_gnt, r0_gnt}, mem_addr_out, expG); end
            rdQ.push_back('{expG[1] ? 1 : 0, expG[1] ? romExp[3] : romExp[0], cyc + 1});
            expLast = expG[1];
        end
        @(negedge clk);
        idleInputs();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            r0_req = 1; r0_addr = AW'(3 - i);
            #1;
            checks++; if ({r1_gnt, r0_gnt} !== 2'b01) begin failures++;
                $display("FAIL back_to_back step=%0d gnt=%b required 01", i, {r1_gnt, r0_gnt}); end
            rdQ.push_back('{0, romExp[3 - i], cyc + 1});
            expLast = 0;
        end
        @(negedge clk);
        idleInputs();
    endtask

    task automatic test_ignored();
        @(negedge clk);
        ld_done = 1; ld_valid = 1; ld_addr = 9; ld_data = 32'h99;
        #1;
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL run_ld_ready actual=%0b required=0", ld_ready); end
        @(negedge clk);
        idleInputs();
        #1;
        checks++; if (run_mode !== 1'b1 || load_count !== (AW+1)'(expCount)) begin failures++;
            $display("FAIL run_ignores_loader run_mode=%0b count=%0d required 1/%0d", run_mode, load_count, expCount); end
    endtask

    task automatic test_reload_with_grant();
        @(negedge clk);
        r0_req = 1; r0_addr = 1; reload_req = 1;
        #1;
        checks++; if ({r1_gnt, r0_gnt} !== 2'b01) begin failures++; $display("FAIL reload_grant gnt=%b required 01", {r1_gnt, r0_gnt}); end
        rdQ.push_back('{0, romExp[1], cyc + 1}); expLast = 0;
        @(negedge clk);
        idleInputs();
        #1;
        checks++; if (run_mode !== 1'b0 || ld_ready !== 1'b0) begin failures++;
            $display("FAIL flush_first run_mode=%0b ld_ready=%0b required 0/0", run_mode, ld_ready); end
        @(negedge clk);
        #1;
        checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL flush_second ld_ready=%0b required 0", ld_ready); end
        @(negedge clk);
        #1;
        checks++; if (ld_ready !== 1'b1 || load_count !== '0 || load_sum !== 32'h0) begin failures++;
            $display("FAIL reload_to_load ld_ready=%0b count=%0d sum=%h required 1/0/0", ld_ready, load_count, load_sum); end
        expCount = 0; expSum = 0;
        @(negedge clk);
        reload_req = 1;
        @(negedge clk);
        reload_req = 0;
        #1;
        checks++; if (ld_ready !== 1'b1 || run_mode !== 1'b0) begin failures++;
            $display("FAIL load_ignores_reload ld_ready=%0b run_mode=%0b required 1/0", ld_ready, run_mode); end
    endtask

    task automatic test_write_guard();
        @(negedge clk);
        ld_valid = 1; ld_addr = 4; ld_data = 32'h55; r1_req = 1; r1_addr = 5;
        #1;
        wrQ.push_back('{ld_addr, ld_data, cyc + 1}); romExp[4] = ld_data; expCount++; expSum += ld_data;
        checks++; if ({r1_gnt, r0_gnt} !== 2'b00) begin failures++; $display("FAIL guard_load_gnt gnt=%b required 00", {r1_gnt, r0_gnt}); end
        @(negedge clk);
        ld_addr = 5; ld_data = 32'h66; ld_done = 1;
        #1;
        wrQ.push_back('{ld_addr, ld_data, cyc + 1}); romExp[5] = ld_data; expCount++; expSum += ld_data;
        @(negedge clk);
        ld_valid = 0; ld_done = 0;
        #1;
        checks++; if ({r1_gnt, r0_gnt} !== 2'b00 || run_mode !== 1'b1) begin failures++;
            $display("FAIL guard_pending gnt=%b run_mode=%0b required 00/1", {r1_gnt, r0_gnt}, run_mode); end
        checks++; if (load_count !== (AW+1)'(expCount) || load_sum !== expSum) begin failures++;
            $display("FAIL guard_stats count=%0d sum=%h required %0d/%h", load_count, load_sum, expCount, expSum); end
        @(negedge clk);
        #1;
        checks++; if ({r1_gnt, r0_gnt} !== 2'b10 || mem_addr_out !== AW'(5)) begin failures++;
            $display("FAIL guard_release gnt=%b addr=%0d required 10/5", {r1_gnt, r0_gnt}, mem_addr_out); end
        rdQ.push_back('{1, romExp[5], cyc + 1}); expLast = 1;
        @(negedge clk);
        idleInputs();
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        r0_req = 1; r0_addr = 4;
        #1;
        checks++; if ({r1_gnt, r0_gnt} !== 2'b01) begin failures++; $display("FAIL midread_gnt gnt=%b required 01", {r1_gnt, r0_gnt}); end
        #2 rst = 1;
        #1 r0_req = 0;
        @(negedge clk);
        #1;
        checks++; if ({r0_rvalid, r1_rvalid, r0_gnt, r1_gnt} !== 4'b0000 || run_mode !== 1'b0 || ld_ready !== 1'b1) begin failures++;
            $display("FAIL midread_reset rvalid/gnt=%b run_mode=%0b ld_ready=%0b required 0000/0/1",
                     {r0_rvalid, r1_rvalid, r0_gnt, r1_gnt}, run_mode, ld_ready); end
        @(negedge clk);
        rst = 0; expLast = 1; expCount = 0; expSum = 0;
        @(negedge clk);
        ld_valid = 1; ld_addr = 7; ld_data = 32'h77;
        @(posedge clk);
        #1 rst = 1; ld_valid = 0;
        #1;
        checks++; if (mem_size_decode !== 4'b0000) begin failures++; $display("FAIL midwrite_decode actual=%b required 0000", mem_size_decode); end
        @(negedge clk);
        #1;
        checks++; if (load_count !== '0 || load_sum !== 32'h0) begin failures++;
            $display("FAIL midwrite_stats count=%0d sum=%h required 0/0", load_count, load_sum); end
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (rom[7] !== 32'h0 || mem_size_decode !== 4'b0000) begin failures++;
            $display("FAIL midwrite_rom rom7=%h decode=%b required 0/0000", rom[7], mem_size_decode); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            rom[i] = 32'h0;
            romExp[i] = 32'h0;
        end
        test_reset();
        test_load();
        test_single_read();
        test_round_robin();
        test_back_to_back();
        test_ignored();
        test_reload_with_grant();
        test_write_guard();
        test_reset_mid_op();
        repeat (3) @(negedge clk);
        checks++; if (rdQ.size() != 0) begin failures++; $display("FAIL reads_outstanding actual=%0d required=0", rdQ.size()); end
        checks++; if (wrQ.size() != 0) begin failures++; $display("FAIL writes_outstanding actual=%0d required=0", wrQ.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
